// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int REG_ADDR_W  = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect (
  input  logic                                 idex_mem_read,
  input  logic [fetch_ctrl_pkg::REG_ADDR_W-1:0] idex_rd,
  input  logic [fetch_ctrl_pkg::REG_ADDR_W-1:0] ifid_rs1,
  input  logic [fetch_ctrl_pkg::REG_ADDR_W-1:0] ifid_rs2,
  output logic                                 load_use_hit
);
  import fetch_ctrl_pkg::*;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency
  assign load_use_hit = idex_mem_read && (idex_rd != REG_X0) &&
                        ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: next-PC selection, PC stall, IF/ID hold/flush and ID/EX bubble
// under branch redirects, instruction-memory latency and load-use hazards.
module fetch_controller #(
  parameter int                  PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  INSTR_BYTES  = fetch_ctrl_pkg::INSTR_BYTES,
  parameter int                  CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PC_WIDTH-1:0]                  pc_current,
  input  logic                                 imem_ready,
  input  logic                                 branch_taken,
  input  logic [PC_WIDTH-1:0]                  branch_target,
  input  logic                                 idex_mem_read,
  input  logic [fetch_ctrl_pkg::REG_ADDR_W-1:0] idex_rd,
  input  logic [fetch_ctrl_pkg::REG_ADDR_W-1:0] ifid_rs1,
  input  logic [fetch_ctrl_pkg::REG_ADDR_W-1:0] ifid_rs2,
  output logic [PC_WIDTH-1:0]                  pc_next,
  output logic                                 pc_stall,
  output logic                                 ifid_write_en,
  output logic                                 ifid_flush,
  output logic                                 idex_bubble,
  output logic [CNT_WIDTH-1:0]                 stall_count
);
  import fetch_ctrl_pkg::*;

  localparam logic [PC_WIDTH-1:0]  PC_INC    = PC_WIDTH'(INSTR_BYTES);
  localparam logic [CNT_WIDTH-1:0] CNT_SATUR = {CNT_WIDTH{1'b1}};

  fetch_state_e state;
  fetch_state_e state_next;
  logic         load_use_hit;

  hazard_detect u_hazard_detect (
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .load_use_hit  (load_use_hit)
  );

  // Priority is branch redirect, then memory latency, then load-use; reset overrides all.
  always_comb begin
    state_next    = state;
    pc_next       = pc_current;
    pc_stall      = 1'b0;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    if (!reset) begin
      state_next    = RUN;
      pc_next       = RESET_VECTOR;
      pc_stall      = 1'b1;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            pc_next     = branch_target;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (!imem_ready) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            state_next = WAIT;
          end else if (load_use_hit) begin
            pc_stall      = 1'b1;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
          end else begin
            pc_next = pc_current + PC_INC;
          end
        end
        WAIT: begin
          if (branch_taken) begin
            // A response arriving with the redirect is simply flushed; otherwise it is stale
            pc_next     = branch_target;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = imem_ready ? RUN : DISCARD;
          end else if (imem_ready) begin
            pc_next    = pc_current + PC_INC;
            state_next = RUN;
          end else begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end
        end
        DISCARD: begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
          if (imem_ready) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      stall_count <= '0;
    end else begin
      state <= state_next;
      if (pc_stall && (stall_count != CNT_SATUR)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: flag-based reference model plus directed literal checks.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_current;
  logic        imem_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic [63:0] pc_next;
  logic        pc_stall;
  logic        ifid_write_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .pc_next       (pc_next),
    .pc_stall      (pc_stall),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: tracks whether a live fetch is pending and whether a stale one is.
  bit m_outstanding = 1'b0;
  bit m_stale = 1'b0;
  int m_stalls = 0;
  logic [63:0] exp_pc_next;
  logic exp_stall, exp_we, exp_flush, exp_bubble, hit;

  always_comb begin
    hit = idex_mem_read && (idex_rd != 5'd0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    exp_pc_next = pc_current;
    exp_stall   = 1'b0;
    exp_we      = 1'b1;
    exp_flush   = 1'b0;
    exp_bubble  = 1'b0;
    if (!reset) begin
      exp_pc_next = 64'h0;
      exp_stall   = 1'b1;
      exp_we      = 1'b0;
      exp_flush   = 1'b1;
      exp_bubble  = 1'b1;
    end else if (m_stale) begin
      exp_stall = 1'b1;
      exp_flush = 1'b1;
    end else if (branch_taken) begin
      exp_pc_next = branch_target;
      exp_flush   = 1'b1;
      exp_bubble  = 1'b1;
    end else if (!imem_ready) begin
      exp_stall = 1'b1;
      exp_flush = 1'b1;
    end else if (!m_outstanding && hit) begin
      exp_stall  = 1'b1;
      exp_we     = 1'b0;
      exp_bubble = 1'b1;
    end else begin
      exp_pc_next = pc_current + 64'd4;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_outstanding <= 1'b0;
      m_stale       <= 1'b0;
      m_stalls      <= 0;
    end else begin
      if (exp_stall && m_stalls < 65535) m_stalls <= m_stalls + 1;
      if (m_stale) begin
        if (imem_ready) m_stale <= 1'b0;
      end else if (branch_taken) begin
        m_stale       <= m_outstanding && !imem_ready;
        m_outstanding <= 1'b0;
      end else begin
        m_outstanding <= !imem_ready;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    checkOutput("pc_next", pc_next, exp_pc_next);
    checkOutput("pc_stall", 64'(pc_stall), 64'(exp_stall));
    checkOutput("ifid_write_en", 64'(ifid_write_en), 64'(exp_we));
    checkOutput("ifid_flush", 64'(ifid_flush), 64'(exp_flush));
    checkOutput("idex_bubble", 64'(idex_bubble), 64'(exp_bubble));
    checkOutput("stall_count", 64'(stall_count), 64'(m_stalls));
  end

  task automatic applyStimulus(input logic rst, input logic [63:0] pc, input logic rdy,
                               input logic br, input logic [63:0] tgt, input logic mr,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    reset         = rst;
    pc_current    = pc;
    imem_ready    = rdy;
    branch_taken  = br;
    branch_target = tgt;
    idex_mem_read = mr;
    idex_rd       = rd;
    ifid_rs1      = rs1;
    ifid_rs2      = rs2;
  endtask

  initial begin
    reset = 1'b0; pc_current = 64'h100; imem_ready = 1'b1; branch_taken = 1'b0;
    branch_target = 64'h0; idex_mem_read = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit_reset_pc_next", pc_next, 64'h0);
    checkOutput("lit_reset_stall", 64'(pc_stall), 64'd1);
    checkOutput("lit_reset_count", 64'(stall_count), 64'd0);

    // Sequential fetch after reset release
    applyStimulus(1, 64'h100, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_seq_pc_next", pc_next, 64'h104);
    checkOutput("lit_seq_stall", 64'(pc_stall), 64'd0);
    checkOutput("lit_seq_flush", 64'({ifid_flush, idex_bubble}), 64'd0);

    // Load x5 followed by a consumer of x5
    applyStimulus(1, 64'h104, 1, 0, 64'h0, 1, 5'd5, 5'd5, 5'd7);
    @(negedge clk);
    checkOutput("lit_lu_stall", 64'({pc_stall, ifid_write_en, idex_bubble}), 64'b101);
    applyStimulus(1, 64'h104, 1, 0, 64'h0, 0, 5'd0, 5'd5, 5'd7);
    @(negedge clk);
    checkOutput("lit_lu_resume", pc_next, 64'h108);
    checkOutput("lit_lu_count", 64'(stall_count), 64'd1);
    // Load to x0 never stalls
    applyStimulus(1, 64'h108, 1, 0, 64'h0, 1, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_x0_nostall", 64'(pc_stall), 64'd0);

    // Taken branch coinciding with a load-use hit: branch wins
    applyStimulus(1, 64'h10C, 1, 1, 64'h2000, 1, 5'd3, 5'd1, 5'd3);
    @(negedge clk);
    checkOutput("lit_br_pc_next", pc_next, 64'h2000);
    checkOutput("lit_br_ctrl", 64'({pc_stall, ifid_write_en, ifid_flush, idex_bubble}), 64'b0111);
    applyStimulus(1, 64'h2000, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);

    // Three-cycle memory latency after a fresh reset
    applyStimulus(0, 64'h40, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 64'h40, 0, 0, 64'h0, 1, 5'd4, 5'd4, 5'd0);
      @(negedge clk);
      checkOutput("lit_wait_stall", 64'({pc_stall, ifid_flush}), 64'b11);
    end
    applyStimulus(1, 64'h40, 1, 0, 64'h0, 1, 5'd4, 5'd4, 5'd0);
    @(negedge clk);
    checkOutput("lit_wait_done", pc_next, 64'h44);
    checkOutput("lit_wait_count", 64'(stall_count), 64'd3);

    // Redirect while waiting; stale response arrives two cycles later
    applyStimulus(1, 64'h80, 0, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 64'h80, 0, 1, 64'h3000, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_wbr_pc_next", pc_next, 64'h3000);
    checkOutput("lit_wbr_stall", 64'(pc_stall), 64'd0);
    applyStimulus(1, 64'h3000, 0, 1, 64'h5000, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_disc_ignore_br", pc_next, 64'h3000);
    checkOutput("lit_disc_ctrl", 64'({pc_stall, ifid_flush, idex_bubble}), 64'b110);
    applyStimulus(1, 64'h3000, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_disc_last", 64'({pc_stall, ifid_flush}), 64'b11);
    applyStimulus(1, 64'h3000, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_disc_refetch", pc_next, 64'h3004);

    // Redirect in WAIT with the response arriving simultaneously: straight back to RUN
    applyStimulus(1, 64'h500, 0, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 64'h500, 1, 1, 64'h600, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 64'h600, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_wbr_ready_run", pc_next, 64'h604);

    // Reset during WAIT returns to RUN, where a load-use hit is honoured
    applyStimulus(1, 64'h700, 0, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 64'h700, 0, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 64'h700, 1, 0, 64'h0, 1, 5'd9, 5'd2, 5'd9);
    @(negedge clk);
    checkOutput("lit_rst_wait_run", 64'({pc_stall, ifid_write_en}), 64'b10);

    // Saturation of the stall counter, then PC wraparound
    applyStimulus(1, 64'h900, 0, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    repeat (70000) @(posedge clk);
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_sat_count", 64'(stall_count), 64'hFFFF);
    checkOutput("lit_wrap_pc_next", pc_next, 64'h0);
    applyStimulus(1, 64'h0, 1, 0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("lit_sat_hold", 64'(stall_count), 64'hFFFF);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
